// File: rtl/pll_sweep_ctrl_if.sv
// Control bundle between the sweep requester and pll_sweep_ctrl.
// master: test/control logic that requests sweeps.
// slave : the sweep sequencer that owns freq_param.
interface pll_sweep_ctrl_if #(
  parameter int DWELL_W = 16
) ();
  logic               start;
  logic               abort;
  logic [7:0]         f_start;
  logic [7:0]         f_stop;
  logic [7:0]         f_step;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         freq_param;
  logic               busy;
  logic               done;
  logic               step_strobe;
  logic               err;

  modport master (
    output start, abort, f_start, f_stop, f_step, dwell,
    input  freq_param, busy, done, step_strobe, err
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, dwell,
    output freq_param, busy, done, step_strobe, err
  );
endinterface

// File: rtl/pll_sweep_ctrl.sv
// pll_sweep_ctrl: steps the PseudoPll 8-bit freq_param from f_start to f_stop
// in f_step increments, holding each value for `dwell` clk_in cycles.
// Optional feature macro: PLL_SWEEP_BIDIR_EN -- when defined, the sweep turns
// at f_stop and walks back to f_start before signalling done.
module pll_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic          clk_in,
  input  logic          reset,
  pll_sweep_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DWELL  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         freq_q;
  logic [7:0]         target;     // value the current leg is heading for
  logic [7:0]         cfg_step;
  logic [DWELL_W-1:0] cfg_dwell_m1;
  logic [DWELL_W-1:0] cnt;        // cycles left on the current value, minus one
  logic               dir_up;
  logic               busy_q;
  logic               done_q;
  logic               strobe_q;
  logic               err_q;
`ifdef PLL_SWEEP_BIDIR_EN
  logic [7:0]         cfg_start;  // return-leg target
  logic               ret_leg;    // set once the sweep has turned at f_stop
  logic [7:0]         turn_val;
`endif
  logic [7:0]         next_val;

  // One step from cur toward tgt. Arithmetic is 9-bit so overflow/underflow
  // is visible; anything past the target or outside 0..255 clamps to tgt.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] stp,
                                             input logic [7:0] tgt,
                                             input logic       up);
    logic [8:0] sum;
    logic [8:0] dif;
    logic [7:0] res;
    sum = {1'b0, cur} + {1'b0, stp};
    dif = {1'b0, cur} - {1'b0, stp};
    res = tgt;
    if (up) begin
      if (sum <= {1'b0, tgt}) res = sum[7:0];
    end else begin
      if (!dif[8] && (dif[7:0] >= tgt)) res = dif[7:0];
    end
    return res;
  endfunction

  // Next sweep value along the current leg (and, bidirectionally, the first
  // value after the turn, which leaves f_stop without repeating it).
  always_comb begin
    next_val = step_toward(freq_q, cfg_step, target, dir_up);
`ifdef PLL_SWEEP_BIDIR_EN
    turn_val = step_toward(freq_q, cfg_step, cfg_start, !dir_up);
`endif
  end

  // Sweep FSM: configuration capture, dwell counting, stepping, completion.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= S_IDLE;
      freq_q       <= 8'd0;
      target       <= 8'd0;
      cfg_step     <= 8'd0;
      cfg_dwell_m1 <= '0;
      cnt          <= '0;
      dir_up       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      strobe_q     <= 1'b0;
      err_q        <= 1'b0;
`ifdef PLL_SWEEP_BIDIR_EN
      cfg_start    <= 8'd0;
      ret_leg      <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sw.start && !sw.abort) begin
            if ((sw.f_step == 8'd0) || (sw.dwell == '0)) begin
              err_q <= 1'b1;
            end else begin
              freq_q       <= sw.f_start;
              target       <= sw.f_stop;
              dir_up       <= (sw.f_stop >= sw.f_start);
              cfg_step     <= sw.f_step;
              cfg_dwell_m1 <= sw.dwell - DWELL_W'(1);
              cnt          <= sw.dwell - DWELL_W'(1);
              strobe_q     <= 1'b1;
              busy_q       <= 1'b1;
              state        <= S_DWELL;
`ifdef PLL_SWEEP_BIDIR_EN
              cfg_start    <= sw.f_start;
              ret_leg      <= 1'b0;
`endif
            end
          end
        end
        S_DWELL: begin
          if (sw.abort) begin
            // freq_param deliberately left at the value being held
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (freq_q != target) begin
            freq_q   <= next_val;
            cnt      <= cfg_dwell_m1;
            strobe_q <= 1'b1;
`ifdef PLL_SWEEP_BIDIR_EN
          end else if (!ret_leg && (cfg_start != target)) begin
            ret_leg  <= 1'b1;
            dir_up   <= !dir_up;
            target   <= cfg_start;
            freq_q   <= turn_val;
            cnt      <= cfg_dwell_m1;
            strobe_q <= 1'b1;
`endif
          end else begin
            // busy drops on the same edge the last dwell ends, so busy spans
            // exactly dwell x values cycles; done marks the FINISH cycle.
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_FINISH;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign sw.freq_param  = freq_q;
  assign sw.busy        = busy_q;
  assign sw.done        = done_q;
  assign sw.step_strobe = strobe_q;
  assign sw.err         = err_q;

endmodule
